// File: rtl/paillier_task_scheduler.sv
// Round-robin dispatch controller for the parallel paillier_top engines.
// Grants idle engines through a valid/ready issue port and counts completions.
module paillier_task_scheduler #(
    parameter  int BLOCK_COUNT = 29,
    parameter  int CNT_W       = 32,
    localparam int IDX_W       = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   paillier_start,
    input  logic [1:0]             paillier_mode,
    input  logic [CNT_W-1:0]       paillier_counts,
    output logic                   paillier_finished,
    output logic                   issue_vld,
    output logic [IDX_W-1:0]       issue_idx,
    input  logic                   issue_rdy,
    output logic [1:0]             task_cmd,
    output logic [BLOCK_COUNT-1:0] task_req,
    input  logic [BLOCK_COUNT-1:0] task_end,
    output logic [BLOCK_COUNT-1:0] eng_busy,
    output logic                   sched_busy,
    output logic                   err_spurious
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [BLOCK_COUNT-1:0] ONE_HOT0 = {{(BLOCK_COUNT-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] popcount(input logic [BLOCK_COUNT-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < BLOCK_COUNT; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Returns {found, index}: first idle engine at or above ptr, wrapping to 0.
    function automatic logic [IDX_W:0] rr_pick(input logic [BLOCK_COUNT-1:0] busy,
                                               input logic [IDX_W-1:0]       ptr);
        logic [IDX_W:0] pick;
        int             pos;
        pick = '0;
        for (int k = BLOCK_COUNT - 1; k >= 0; k--) begin
            pos  = int'(ptr) + k;
            pos  = (pos >= BLOCK_COUNT) ? pos - BLOCK_COUNT : pos;
            pick = busy[pos[IDX_W-1:0]] ? pick : {1'b1, pos[IDX_W-1:0]};
        end
        return pick;
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [1:0]             mode_r;
    logic [CNT_W-1:0]       counts_r, issued_r, done_r;
    logic [CNT_W-1:0]       issued_nxt_s, done_nxt_s;
    logic [IDX_W-1:0]       rr_ptr_r, idx_r, idx_nxt_s;
    logic [BLOCK_COUNT-1:0] busy_r, busy_nxt_s, req_r;
    logic [BLOCK_COUNT-1:0] grant_mask_s, valid_end_s;
    logic                   vld_r, vld_nxt_s;
    logic                   fin_r, sched_busy_r, err_r;
    logic                   hs_s, start_acc_s, spurious_s;
    logic [IDX_W:0]         pick_s;

    // Busy bits only see task_end through the register, so a freed engine becomes
    // eligible one cycle after its completion pulse.
    assign pick_s       = rr_pick(busy_r, rr_ptr_r);
    assign hs_s         = vld_r & issue_rdy;
    assign grant_mask_s = hs_s ? (ONE_HOT0 << idx_r) : '0;
    assign valid_end_s  = task_end & busy_r;
    assign spurious_s   = |(task_end & ~busy_r);
    assign busy_nxt_s   = (busy_r & ~valid_end_s) | grant_mask_s;
    assign done_nxt_s   = done_r + popcount(valid_end_s);
    assign issued_nxt_s = issued_r + CNT_W'(hs_s);
    assign start_acc_s  = (state_r == ST_IDLE) && paillier_start;

    // Next-state logic for the job sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (paillier_start) begin
                    state_nxt_s = (paillier_counts == '0) ? ST_DONE : ST_DISPATCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (issued_r == counts_r) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                if ((done_nxt_s == counts_r) && (busy_nxt_s == '0)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Issue port: hold a pending grant until accepted, then idle for one cycle.
    always_comb begin
        vld_nxt_s = 1'b0;
        idx_nxt_s = idx_r;
        if (vld_r) begin
            vld_nxt_s = ~issue_rdy;
        end else if ((state_r == ST_DISPATCH) && (issued_r < counts_r) && pick_s[IDX_W]) begin
            vld_nxt_s = 1'b1;
            idx_nxt_s = pick_s[IDX_W-1:0];
        end else begin
            vld_nxt_s = 1'b0;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            mode_r       <= 2'b00;
            counts_r     <= '0;
            issued_r     <= '0;
            done_r       <= '0;
            rr_ptr_r     <= '0;
            busy_r       <= '0;
            req_r        <= '0;
            vld_r        <= 1'b0;
            idx_r        <= '0;
            fin_r        <= 1'b0;
            sched_busy_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= busy_nxt_s;
            req_r        <= grant_mask_s;
            vld_r        <= vld_nxt_s;
            idx_r        <= idx_nxt_s;
            fin_r        <= (state_r == ST_DONE);
            sched_busy_r <= (state_nxt_s != ST_IDLE);
            err_r        <= (start_acc_s ? 1'b0 : err_r) | spurious_s;
            if (start_acc_s) begin
                mode_r   <= paillier_mode;
                counts_r <= paillier_counts;
                issued_r <= '0;
                done_r   <= '0;
            end else begin
                issued_r <= issued_nxt_s;
                done_r   <= done_nxt_s;
            end
            if (hs_s) begin
                rr_ptr_r <= (idx_r == IDX_W'(BLOCK_COUNT - 1)) ? '0 : idx_r + IDX_W'(1'b1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign paillier_finished = fin_r;
    assign issue_vld         = vld_r;
    assign issue_idx         = idx_r;
    assign task_cmd          = mode_r;
    assign task_req          = req_r;
    assign eng_busy          = busy_r;
    assign sched_busy        = sched_busy_r;
    assign err_spurious      = err_r;

endmodule

// File: tb/tb_paillier_task_scheduler.sv
// Scoreboard bench for paillier_task_scheduler with 4 engines: expected grants
// and job completions are queued by the stimulus and checked by a monitor.
module tb_paillier_task_scheduler;
    localparam int BC  = 4;
    localparam int CW  = 32;
    localparam int IW  = 2;
    localparam int LAT = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          paillier_start;
    logic [1:0]    paillier_mode;
    logic [CW-1:0] paillier_counts;
    logic          paillier_finished;
    logic          issue_vld;
    logic [IW-1:0] issue_idx;
    logic          issue_rdy;
    logic [1:0]    task_cmd;
    logic [BC-1:0] task_req;
    logic [BC-1:0] task_end;
    logic [BC-1:0] eng_busy;
    logic          sched_busy;
    logic          err_spurious;

    logic [BC-1:0] manual_end;
    logic [BC-1:0] auto_end_bits;
    bit            auto_mode;
    int            timer [BC];
    int            total, bad;
    int            req_cnt, fin_cnt, job_reqs;
    int            exp_req[$];
    int            exp_fin[$];
    int            e;
    int            base, fbase;

    assign task_end = manual_end | auto_end_bits;

    paillier_task_scheduler #(.BLOCK_COUNT(BC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .paillier_start(paillier_start), .paillier_mode(paillier_mode),
        .paillier_counts(paillier_counts), .paillier_finished(paillier_finished),
        .issue_vld(issue_vld), .issue_idx(issue_idx), .issue_rdy(issue_rdy),
        .task_cmd(task_cmd), .task_req(task_req), .task_end(task_end),
        .eng_busy(eng_busy), .sched_busy(sched_busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input logic [1:0] m, input int unsigned c);
        paillier_mode   = m;
        paillier_counts = c;
        paillier_start  = 1'b1;
        step();
        paillier_start  = 1'b0;
    endtask

    task automatic pulse_end(input logic [BC-1:0] mask);
        manual_end = mask;
        step();
        manual_end = '0;
    endtask

    task automatic wait_reqs(input int target, input int budget);
        int n = 0;
        while (req_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk("req_wait", req_cnt, target);
    endtask

    task automatic wait_fin(input int target, input int budget);
        int n = 0;
        while (fin_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk("fin_wait", fin_cnt, target);
    endtask

    // Engine model: each granted engine answers LAT cycles later when auto_mode is set.
    initial begin
        auto_end_bits = '0;
        for (int i = 0; i < BC; i++) timer[i] = 0;
        forever begin
            @(negedge clk);
            auto_end_bits = '0;
            for (int i = 0; i < BC; i++) begin
                if (rst) begin
                    timer[i] = 0;
                end else begin
                    if (timer[i] != 0) begin
                        timer[i]--;
                        if (timer[i] == 0) auto_end_bits[i] = 1'b1;
                    end
                    if (task_req[i] && auto_mode) timer[i] = LAT;
                end
            end
        end
    end

    // Monitor: pops expected grant / job entries whenever the DUT pulses them.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) job_reqs = 0;
            if (task_req != '0) begin
                req_cnt++;
                job_reqs++;
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", task_req, 0);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_onehot", task_req, 1 << e);
                end
            end
            if (paillier_finished) begin
                fin_cnt++;
                if (exp_fin.size() == 0) begin
                    chk("fin_unexpected", paillier_finished, 0);
                end else begin
                    chk("fin_job_reqs", job_reqs, exp_fin.pop_front());
                end
                job_reqs = 0;
            end
        end
    end

    initial begin
        total = 0; bad = 0; req_cnt = 0; fin_cnt = 0; job_reqs = 0;
        rst = 1'b1; paillier_start = 1'b0; paillier_mode = 2'b00;
        paillier_counts = '0; issue_rdy = 1'b1; manual_end = '0; auto_mode = 1'b0;
        step(); step();
        chk("rst_vld", issue_vld, 0);
        chk("rst_idx", issue_idx, 0);
        chk("rst_req", task_req, 0);
        chk("rst_busy", eng_busy, 0);
        chk("rst_sched", sched_busy, 0);
        chk("rst_fin", paillier_finished, 0);
        chk("rst_cmd", task_cmd, 0);
        chk("rst_err", err_spurious, 0);
        rst = 1'b0;
        step();

        // counts=3, grants 0,1,2 on alternating cycles, finish 1 cycle after done
        auto_mode = 1'b1;
        exp_req.push_back(0); exp_req.push_back(1); exp_req.push_back(2);
        exp_fin.push_back(3);
        start_job(2'd2, 3);
        chk("t1_sched", sched_busy, 1);
        chk("t1_cmd", task_cmd, 2);
        step();
        chk("t1_vld0", issue_vld, 1);
        chk("t1_idx0", issue_idx, 0);
        chk("t1_noreq", task_req, 0);
        step();
        chk("t1_req0", task_req, 4'b0001);
        chk("t1_vld_drop", issue_vld, 0);
        step();
        chk("t1_idx1", issue_idx, 1);
        chk("t1_gap", task_req, 0);
        step();
        chk("t1_req1", task_req, 4'b0010);
        step();
        step();
        chk("t1_req2", task_req, 4'b0100);
        repeat (11) step();
        chk("t1_busy_clear", eng_busy, 0);
        chk("t1_fin_early", paillier_finished, 0);
        step();
        chk("t1_fin", paillier_finished, 1);
        chk("t1_sched_idle", sched_busy, 0);
        step();
        chk("t1_fin_pulse", paillier_finished, 0);

        rst = 1'b1; step(); rst = 1'b0; step();

        // counts=6 with all engines held busy
        auto_mode = 1'b0;
        base = req_cnt; fbase = fin_cnt;
        exp_req.push_back(0); exp_req.push_back(1); exp_req.push_back(2);
        exp_req.push_back(3); exp_req.push_back(2); exp_req.push_back(0);
        exp_fin.push_back(6);
        start_job(2'd1, 6);
        wait_reqs(base + 4, 20);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_full_vld", issue_vld, 0);
            chk("t2_full_busy", eng_busy, 4'hF);
        end
        pulse_end(4'b0100);
        chk("t2_freed", eng_busy, 4'hB);
        wait_reqs(base + 5, 10);
        chk("t2_regrant", eng_busy, 4'hF);
        pulse_end(4'b0001);
        wait_reqs(base + 6, 10);
        pulse_end(4'b0010);
        repeat (3) step();
        chk("t2_no_early_fin", fin_cnt, fbase);
        pulse_end(4'b1101);
        wait_fin(fbase + 1, 10);

        // issue_rdy low for 5 cycles: grant to engine 1 (rr_ptr=1) held stable
        auto_mode = 1'b1;
        issue_rdy = 1'b0;
        fbase = fin_cnt;
        exp_req.push_back(1);
        exp_fin.push_back(1);
        start_job(2'd0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_vld", issue_vld, 1);
            chk("t4_hold_idx", issue_idx, 1);
            chk("t4_hold_noreq", task_req, 0);
        end
        issue_rdy = 1'b1;
        step();
        chk("t4_req", task_req, 4'b0010);
        wait_fin(fbase + 1, 30);

        // spurious end on idle engine 3 and an ignored mid-job start
        auto_mode = 1'b0;
        base = req_cnt; fbase = fin_cnt;
        exp_req.push_back(2); exp_req.push_back(3);
        exp_fin.push_back(2);
        start_job(2'd1, 2);
        wait_reqs(base + 1, 10);
        pulse_end(4'b1000);
        chk("t5_err", err_spurious, 1);
        start_job(2'd3, 7);
        chk("t5_cmd_kept", task_cmd, 1);
        chk("t5_still_busy", sched_busy, 1);
        wait_reqs(base + 2, 10);
        pulse_end(4'b0100);
        repeat (3) step();
        chk("t5_no_early_fin", fin_cnt, fbase);
        chk("t5_err_sticky", err_spurious, 1);
        pulse_end(4'b1000);
        wait_fin(fbase + 1, 10);

        // counts=0: finished 2 cycles after start, sched_busy for 1 cycle
        exp_fin.push_back(0);
        start_job(2'd3, 0);
        chk("t3_sched", sched_busy, 1);
        chk("t3_fin_early", paillier_finished, 0);
        chk("t3_err_cleared", err_spurious, 0);
        step();
        chk("t3_fin", paillier_finished, 1);
        chk("t3_sched_idle", sched_busy, 0);
        chk("t3_cmd", task_cmd, 3);
        step();
        chk("t3_fin_pulse", paillier_finished, 0);

        // async reset with two engines busy, then a fresh single-task job
        base = req_cnt;
        exp_req.push_back(0); exp_req.push_back(1);
        start_job(2'd2, 3);
        wait_reqs(base + 2, 10);
        chk("t6_busy", eng_busy, 4'b0011);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", eng_busy, 0);
        chk("t6_rst_vld", issue_vld, 0);
        chk("t6_rst_sched", sched_busy, 0);
        chk("t6_rst_cmd", task_cmd, 0);
        chk("t6_rst_req", task_req, 0);
        chk("t6_rst_fin", paillier_finished, 0);
        step(); rst = 1'b0; step();
        auto_mode = 1'b1;
        fbase = fin_cnt;
        exp_req.push_back(0);
        exp_fin.push_back(1);
        start_job(2'd1, 1);
        wait_fin(fbase + 1, 30);

        step();
        chk("leftover_req", exp_req.size(), 0);
        chk("leftover_fin", exp_fin.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/paillier_task_scheduler.md
Name: paillier_task_scheduler

Overview:
Dispatch controller sitting between the AXI-Lite control registers (start/mode/counts/finished) and the BLOCK_COUNT parallel paillier_top engines. It hands each of `counts` tasks to an idle engine using round-robin selection. Each grant is exported to the operand loader through a valid/ready issue handshake, and the block pulses that engine's task_req. It then tracks task_end completions and raises finished once every task has returned.

Parameters:
BLOCK_COUNT, 29, number of paillier_top engines.
CNT_W, 32, width of task count and counters.
IDX_W, $clog2(BLOCK_COUNT), engine index width (localparam).

Ports:
clk  in  1  single clock for all logic.
rst  in  1  asynchronous reset, active-high.
paillier_start  in  1  start pulse from control registers.
paillier_mode  in  2  task command, latched on accepted start.
paillier_counts  in  CNT_W  total tasks, latched on accepted start.
paillier_finished  out  1  one-cycle pulse when the job completes.
issue_vld  out  1  a grant to engine issue_idx is pending.
issue_idx  out  IDX_W  engine index of the pending grant.
issue_rdy  in  1  operand loader accepts the grant.
task_cmd  out  2  latched mode, broadcast to all engines.
task_req  out  BLOCK_COUNT  one-hot, one-cycle request pulse per engine.
task_end  in  BLOCK_COUNT  per-engine completion pulses.
eng_busy  out  BLOCK_COUNT  engine-busy bitmap.
sched_busy  out  1  high when the state is not IDLE.
err_spurious  out  1  sticky flag: task_end seen on a non-busy engine.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr, issue counter and done counter all 0.
- State IDLE:
  - paillier_start=1 latches mode and counts.
  - counts==0 -> go to DONE.
  - otherwise -> go to DISPATCH.
  - err_spurious is cleared on an accepted start.
- State DISPATCH:
  - If issued < counts and any engine is idle (~eng_busy), present issue_vld=1 with issue_idx = the first idle engine searching upward from rr_ptr, wrapping at BLOCK_COUNT-1 -> 0.
  - issue_idx stays stable while issue_vld=1 and issue_rdy=0.
  - On issue_vld&&issue_rdy:
    - eng_busy[idx] is set next cycle.
    - task_req[idx]=1 for exactly the next cycle.
    - issued is incremented.
    - rr_ptr becomes idx+1, wrapping to 0.
  - issue_vld drops for at least one cycle after each handshake (at most one grant per 2 cycles).
  - When issued==counts -> go to DRAIN.
- State DRAIN: wait until done==counts and eng_busy==0, then go to DONE.
- State DONE: paillier_finished=1 for one cycle, then go to IDLE.
- Completion handling, in all states: task_end[i] with eng_busy[i]=1 clears eng_busy[i] and increments done.
  - Several task_end bits may arrive in one cycle; done adds the popcount.
  - task_end[i] with eng_busy[i]=0 is ignored for counting and sets err_spurious.
- Simultaneous events:
  - A task_end on an engine makes it eligible for a grant the following cycle, not the same cycle.
  - A handshake and a task_end on different engines in the same cycle both take effect.
- paillier_start while not IDLE is ignored; the latched mode and counts are unchanged.
- task_cmd holds the latched mode until the next accepted start.
- All engines busy: issue_vld=0 until one frees up. This is not an error.
- Asynchronous reset mid-job returns to IDLE immediately, with all busy bits and counters cleared and no finished pulse.
- Counters are CNT_W wide. Because issued and done are each ≤ counts, they never wrap.

Test Plan:
- BLOCK_COUNT=4, counts=3, issue_rdy=1, engines end 10 cycles after req -> task_req to engines 0, 1, 2 on alternating cycles; finished pulses once, 1 cycle after done reaches 3 in DRAIN.
- counts=6, BLOCK_COUNT=4, no task_end until all 4 are busy -> issue_vld=0 while eng_busy=4'hF; task_end[2] frees engine 2, which is granted next (rr_ptr=0, only idle); finished after 6 completions.
- counts=0, start -> finished pulses 2 cycles after start; no task_req; sched_busy high for 1 cycle.
- issue_rdy held low 5 cycles -> issue_vld and issue_idx stable for 5 cycles; task_req fires only the cycle after issue_rdy rises.
- task_end[3] on an idle engine during DISPATCH -> err_spurious=1 and done unchanged; a second start mid-job is ignored and task_cmd is unchanged.
- Assert rst while 2 engines are busy in DISPATCH -> all outputs 0 immediately; a new start with counts=1 completes normally and grants engine 0.
